// File: rtl/regfile_scoreboard.sv
// Register file with scoreboard.
// Two registered read ports and one write port, with write-to-read bypass.
// Register 0 can optionally be hardwired to zero.
// Each register has a pending bit, and a counter tracks how many bits are set.
// The pending bits drive a hazard stall towards the pipeline control.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] dataa,
    output logic [DATA_WIDTH-1:0] datab,
    output logic                  busya,
    output logic                  busyb,
    output logic                  stall,
    input  logic                  enc,
    input  logic [ADDR_WIDTH-1:0] addrc,
    input  logic [DATA_WIDTH-1:0] datac,
    input  logic                  issue,
    input  logic [ADDR_WIDTH-1:0] addrd,
    output logic [ADDR_WIDTH:0]   pending_count
);

    localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic                ZERO_EN    = (ZERO_REG != 0);

    // An address is usable if it is implemented and is not the hardwired zero register.
    function automatic logic addr_valid(input logic [ADDR_WIDTH-1:0] addr);
        addr_valid = ({1'b0, addr} < NUM_REGS_W) && !(ZERO_EN && (addr == '0));
    endfunction

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_next;
    logic                  write_ok;
    logic                  issue_ok;
    logic                  read_ok_a;
    logic                  read_ok_b;
    logic                  count_inc;
    logic                  count_dec;
    logic [ADDR_WIDTH:0]   count_next;
    logic [DATA_WIDTH-1:0] read_val_a;
    logic [DATA_WIDTH-1:0] read_val_b;

    // Qualify each request against the valid address range.
    always_comb begin
        write_ok  = enc && addr_valid(addrc);
        issue_ok  = issue && addr_valid(addrd);
        read_ok_a = addr_valid(addra);
        read_ok_b = addr_valid(addrb);
    end

    // Pending bits after this edge. A write clears the bit and an issue sets it.
    // The issue is applied last, so it wins when both target the same register.
    always_comb begin
        pending_next = pending;
        if (write_ok) begin
            pending_next[addrc] = 1'b0;
        end
        if (issue_ok) begin
            pending_next[addrd] = 1'b1;
        end
    end

    // Count only real bit transitions.
    // When a write and an issue hit the same register, the issue leaves the bit
    // set, so that write does not decrement the count.
    always_comb begin
        count_inc  = issue_ok && !pending[addrd];
        count_dec  = write_ok && pending[addrc] && !(issue_ok && (addrd == addrc));
        count_next = pending_count + (ADDR_WIDTH+1)'(count_inc)
                                   - (ADDR_WIDTH+1)'(count_dec);
    end

    // Read data as it stands after this edge's write.
    // A write to the address being read this edge is bypassed straight through.
    always_comb begin
        read_val_a = '0;
        read_val_b = '0;
        if (read_ok_a) begin
            read_val_a = (write_ok && (addrc == addra)) ? datac : regs[addra];
        end
        if (read_ok_b) begin
            read_val_b = (write_ok && (addrc == addrb)) ? datac : regs[addrb];
        end
    end

    // Register storage. Writes to invalid addresses were already filtered out by write_ok.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[addrc] <= datac;
        end
    end

    // Scoreboard state and the registered read outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending       <= '0;
            pending_count <= '0;
            dataa         <= '0;
            datab         <= '0;
            busya         <= 1'b0;
            busyb         <= 1'b0;
        end else begin
            pending       <= pending_next;
            pending_count <= count_next;
            dataa         <= read_val_a;
            datab         <= read_val_b;
            busya         <= read_ok_a ? pending_next[addra] : 1'b0;
            busyb         <= read_ok_b ? pending_next[addrb] : 1'b0;
        end
    end

    assign stall = busya | busyb;

endmodule
